// File: rtl/noc16_aes_loader.sv
// noc16_aes_loader
// Host-side initiator for the NOC16 AES peripheral link. After a start pulse
// it streams the expanded round key (RK_CHUNKS x 64b, CMD_RK), then the IV
// (2 x 64b, CMD_IV), then data_len data chunks taken from the din stream
// (CMD_DATA) over a valid/rdy TX channel. Independently, it captures response
// words tagged CMD_RESP from the RX channel.
//
// Ports
//   clk, reset_n                  clock, asynchronous active-low reset
//   start, data_len, rk_in, iv_in load request and the operands it latches
//   din_data, din_valid, din_rdy  data chunk stream into the loader
//   tx_lo, tx_cmd, tx_valid, tx_rdy  NOC16 TX channel
//   rx_lo, rx_cmd, rx_valid, rx_rdy  NOC16 RX channel
//   busy, done                    load in progress / one-cycle completion pulse
//   resp_data, resp_valid, resp_count  captured responses
//   err                           sticky TX stall timeout flag
//
// Optional feature: define NOC16_LOADER_TIMEOUT_EN to abort a load after
// TIMEOUT_CYCLES consecutive stalled TX cycles. Without it err is tied to 0.
module noc16_aes_loader #(
    parameter int          RK_CHUNKS      = 22,
    parameter int          LEN_W          = 16,
    parameter logic [7:0]  CMD_RK         = 8'h00,
    parameter logic [7:0]  CMD_IV         = 8'h01,
    parameter logic [7:0]  CMD_DATA       = 8'h02,
    parameter logic [7:0]  CMD_RESP       = 8'hEF,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [LEN_W-1:0]        data_len,
    input  logic [RK_CHUNKS*64-1:0] rk_in,
    input  logic [127:0]            iv_in,
    input  logic [63:0]             din_data,
    input  logic                    din_valid,
    output logic                    din_rdy,
    output logic [63:0]             tx_lo,
    output logic [7:0]              tx_cmd,
    output logic                    tx_valid,
    input  logic                    tx_rdy,
    input  logic [63:0]             rx_lo,
    input  logic [7:0]              rx_cmd,
    input  logic                    rx_valid,
    output logic                    rx_rdy,
    output logic                    busy,
    output logic                    done,
    output logic [63:0]             resp_data,
    output logic                    resp_valid,
    output logic [15:0]             resp_count,
    output logic                    err
);

    localparam int IDX_W = $clog2(RK_CHUNKS);
    localparam logic [IDX_W-1:0] RK_LAST = IDX_W'(RK_CHUNKS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    typedef enum logic [2:0] {IDLE, SEND_RK, SEND_IV, SEND_DATA, DONE} state_t;

    state_t                  state;
    logic [RK_CHUNKS*64-1:0] rk_sh;      // upcoming round-key chunks, next one in [63:0]
    logic [127:0]            iv_q;
    logic [LEN_W-1:0]        remaining;  // data chunks not yet pulled from din
    logic [IDX_W-1:0]        idx;        // index of the chunk currently on tx_*

    logic hs;
    logic rem_nz;
    logic iv_last;
    logic din_take;

    assign hs       = tx_valid & tx_rdy;
    assign rem_nz   = (remaining != '0);
    assign iv_last  = (state == SEND_IV) && (idx == IDX_ONE);
    // The first data chunk may load on the final IV handshake so that a
    // fully-ready link sees the whole load back to back without a bubble.
    assign din_rdy  = rem_nz & (((state == SEND_DATA) & (!tx_valid | tx_rdy)) | (iv_last & hs));
    assign din_take = din_valid & din_rdy;
    assign busy     = (state != IDLE);

`ifdef NOC16_LOADER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] stall_cnt;
`else
    assign err = 1'b0;
`endif

    // Load sequencer: every TX handshake loads the next word on the same edge,
    // so tx_lo/tx_cmd only change on a handshake or when tx_valid is low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            rk_sh     <= '0;
            iv_q      <= '0;
            remaining <= '0;
            idx       <= '0;
            tx_lo     <= '0;
            tx_cmd    <= '0;
            tx_valid  <= 1'b0;
            done      <= 1'b0;
`ifdef NOC16_LOADER_TIMEOUT_EN
            stall_cnt <= '0;
            err       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rk_sh     <= rk_in >> 64;
                        iv_q      <= iv_in;
                        remaining <= data_len;
                        tx_lo     <= rk_in[63:0];
                        tx_cmd    <= CMD_RK;
                        tx_valid  <= 1'b1;
                        idx       <= '0;
                        state     <= SEND_RK;
`ifdef NOC16_LOADER_TIMEOUT_EN
                        err       <= 1'b0;
`endif
                    end
                end
                SEND_RK: begin
                    if (hs) begin
                        if (idx == RK_LAST) begin
                            tx_lo  <= iv_q[63:0];
                            tx_cmd <= CMD_IV;
                            idx    <= '0;
                            state  <= SEND_IV;
                        end else begin
                            tx_lo  <= rk_sh[63:0];
                            rk_sh  <= rk_sh >> 64;
                            idx    <= idx + IDX_ONE;
                        end
                    end
                end
                SEND_IV: begin
                    if (hs) begin
                        if (idx == '0) begin
                            tx_lo <= iv_q[127:64];
                            idx   <= IDX_ONE;
                        end else if (din_take) begin
                            tx_lo     <= din_data;
                            tx_cmd    <= CMD_DATA;
                            remaining <= remaining - LEN_W'(1);
                            state     <= SEND_DATA;
                        end else begin
                            tx_valid <= 1'b0;
                            if (!rem_nz) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= SEND_DATA;
                            end
                        end
                    end
                end
                SEND_DATA: begin
                    if (din_take) begin
                        tx_lo     <= din_data;
                        tx_cmd    <= CMD_DATA;
                        tx_valid  <= 1'b1;
                        remaining <= remaining - LEN_W'(1);
                    end else if (hs) begin
                        tx_valid <= 1'b0;
                        if (!rem_nz) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
`ifdef NOC16_LOADER_TIMEOUT_EN
            // A stalled word blocks everything above, so the abort can simply
            // override the case statement's (unchanged) results.
            if (tx_valid & !tx_rdy) begin
                if (stall_cnt == STALL_LAST) begin
                    stall_cnt <= '0;
                    tx_valid  <= 1'b0;
                    err       <= 1'b1;
                    state     <= IDLE;
                end else begin
                    stall_cnt <= stall_cnt + CNT_W'(1);
                end
            end else begin
                stall_cnt <= '0;
            end
`endif
        end
    end

    // Response capture runs regardless of the load state; non-response tags
    // are accepted and dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_rdy     <= 1'b0;
            resp_data  <= '0;
            resp_valid <= 1'b0;
            resp_count <= '0;
        end else begin
            rx_rdy     <= 1'b1;
            resp_valid <= 1'b0;
            if (rx_valid && rx_rdy && (rx_cmd == CMD_RESP)) begin
                resp_data  <= rx_lo;
                resp_valid <= 1'b1;
                if (resp_count != 16'hFFFF) begin
                    resp_count <= resp_count + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_noc16_aes_loader.sv
// tb_noc16_aes_loader
// Self-checking bench for noc16_aes_loader. The reference model is a queue of
// expected TX words built from the load operands (round-key chunks, IV halves,
// then the din source values in order), plus a running response model for RX.
// One negedge process compares the DUT against the model every cycle.
module tb_noc16_aes_loader;

    localparam int RK = 22;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            start = 1'b0;
    logic [15:0]     data_len = '0;
    logic [RK*64-1:0] rk_in = '0;
    logic [127:0]    iv_in = '0;
    logic [63:0]     din_data = '0;
    logic            din_valid = 1'b0;
    logic            din_rdy;
    logic [63:0]     tx_lo;
    logic [7:0]      tx_cmd;
    logic            tx_valid;
    logic            tx_rdy = 1'b1;
    logic [63:0]     rx_lo = '0;
    logic [7:0]      rx_cmd = '0;
    logic            rx_valid = 1'b0;
    logic            rx_rdy;
    logic            busy;
    logic            done;
    logic [63:0]     resp_data;
    logic            resp_valid;
    logic [15:0]     resp_count;
    logic            err;

    noc16_aes_loader #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .data_len(data_len),
        .rk_in(rk_in), .iv_in(iv_in), .din_data(din_data), .din_valid(din_valid),
        .din_rdy(din_rdy), .tx_lo(tx_lo), .tx_cmd(tx_cmd), .tx_valid(tx_valid),
        .tx_rdy(tx_rdy), .rx_lo(rx_lo), .rx_cmd(rx_cmd), .rx_valid(rx_valid),
        .rx_rdy(rx_rdy), .busy(busy), .done(done), .resp_data(resp_data),
        .resp_valid(resp_valid), .resp_count(resp_count), .err(err)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    // model state
    logic [63:0] exp_lo[$];
    logic [7:0]  exp_cmd[$];
    logic [63:0] src[$];
    int src_idx = 0, cur_len = 0, words_seen = 0, first_cycle = 0, last_hs = -10;
    int done_count = 0, done_cycle = 0, start_cyc = 0, rst_cnt = 0, rv_pulses = 0;
    bit prev_stall = 0;
    logic [63:0] prev_lo = '0;
    logic [7:0]  prev_cmd = '0;
    logic [63:0] m_resp_data = '0;
    logic [15:0] m_resp_cnt = '0;
    bit m_rv = 0;
    int rdy_mode = 0, din_mode = 0, rx_mode = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // input drivers, all updated just after the active edge
    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0: tx_rdy = 1'b1;
            1: tx_rdy = ~tx_rdy;
            2: tx_rdy = 1'($urandom_range(0, 1));
            default: tx_rdy = 1'b0;
        endcase
        din_valid = (din_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        din_data  = (src_idx < src.size()) ? src[src_idx] : {$urandom, $urandom};
        if (rx_mode == 1) begin
            rx_valid = ($urandom_range(0, 2) == 0);
            rx_cmd   = ($urandom_range(0, 1) == 1) ? 8'hEF : 8'($urandom_range(0, 255));
            rx_lo    = {$urandom, $urandom};
        end
    end

    // compare process
    initial forever begin
        @(negedge clk);
        if (!reset_n) begin
            exp_lo.delete(); exp_cmd.delete();
            m_resp_data = '0; m_resp_cnt = '0; m_rv = 0;
            prev_stall = 0; rst_cnt = 0;
        end else begin
            rst_cnt++;
            checkOutput("rx_rdy", rx_rdy, (rst_cnt >= 2));
            checkOutput("resp_valid", resp_valid, m_rv);
            checkOutput("resp_data", resp_data, m_resp_data);
            checkOutput("resp_count", resp_count, m_resp_cnt);
            if (resp_valid) rv_pulses++;
            m_rv = 0;
            if (rst_cnt >= 2 && rx_valid && rx_cmd == 8'hEF) begin
                m_resp_data = rx_lo;
                if (m_resp_cnt != 16'hFFFF) m_resp_cnt++;
                m_rv = 1;
            end
`ifndef NOC16_LOADER_TIMEOUT_EN
            checkOutput("err_tied_low", err, 0);
`endif
            if (prev_stall) begin
`ifndef NOC16_LOADER_TIMEOUT_EN
                checkOutput("tx_valid_hold", tx_valid, 1);
`endif
                if (tx_valid) begin
                    checkOutput("tx_lo_hold", tx_lo, prev_lo);
                    checkOutput("tx_cmd_hold", tx_cmd, prev_cmd);
                end
            end
            prev_stall = tx_valid && !tx_rdy;
            prev_lo = tx_lo;
            prev_cmd = tx_cmd;
            if (tx_valid) checkOutput("busy_while_tx", busy, 1);
            if (tx_valid && tx_rdy) begin
                if (exp_lo.size() == 0) begin
                    compared++; mismatched++;
                    $display("[TB] FAIL tx_extra_word: got word 0x%0h, required no word (cycle %0d)", tx_lo, cyc);
                end else begin
                    checkOutput("tx_cmd", tx_cmd, exp_cmd.pop_front());
                    checkOutput("tx_lo", tx_lo, exp_lo.pop_front());
                end
                if (words_seen == 0) first_cycle = cyc;
                words_seen++;
                last_hs = cyc;
            end
            if (din_rdy) begin
                compared++;
                if (src_idx >= cur_len) begin
                    mismatched++;
                    $display("[TB] FAIL din_rdy_excess: got din_rdy 1 after %0d chunks, required 0", src_idx);
                end
                if (din_valid) src_idx++;
            end
            if (done) begin
                checkOutput("done_after_last_hs", cyc, last_hs + 1);
                checkOutput("done_queue_empty", exp_lo.size(), 0);
                done_count++;
                done_cycle = cyc;
            end
        end
    end

    task automatic doReset();
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        checkOutput("rst_tx_valid", tx_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_tx_lo", tx_lo, 0);
        checkOutput("rst_tx_cmd", tx_cmd, 0);
        checkOutput("rst_resp_count", resp_count, 0);
        checkOutput("rst_err", err, 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // Builds the expected word sequence for one load and pulses start.
    task automatic loadSetup(input int len, input bit directed);
        logic [63:0] v;
        @(posedge clk); #1;
        exp_lo.delete(); exp_cmd.delete(); src.delete();
        for (int i = 0; i < RK; i++) begin
            v = directed ? 64'(i) : {$urandom, $urandom};
            rk_in[i*64 +: 64] = v;
            exp_cmd.push_back(8'h00); exp_lo.push_back(v);
        end
        iv_in = directed ? {64'hB, 64'hA} : {$urandom, $urandom, $urandom, $urandom};
        exp_cmd.push_back(8'h01); exp_lo.push_back(iv_in[63:0]);
        exp_cmd.push_back(8'h01); exp_lo.push_back(iv_in[127:64]);
        for (int j = 0; j < len; j++) begin
            v = {$urandom, $urandom};
            src.push_back(v);
            exp_cmd.push_back(8'h02); exp_lo.push_back(v);
        end
        src_idx = 0; cur_len = len; words_seen = 0; done_count = 0; last_hs = -10;
        data_len = 16'(len);
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic applyStimulus(input int len, input bit directed, input int rmode, input int dmode);
        int n;
        rdy_mode = rmode;
        din_mode = dmode;
        loadSetup(len, directed);
        if (!directed) begin
            repeat (3) @(posedge clk);
            #1 start = 1'b1; data_len = 16'($urandom_range(0, 9));
            @(posedge clk); #1 start = 1'b0;
        end
        n = 0;
        while (done_count == 0 && n < 3000) begin
            @(negedge clk); #1;
            n++;
        end
        if (done_count == 0) begin
            compared++; mismatched++;
            $display("[TB] FAIL done_timeout: got no done, required done within 3000 cycles");
        end
        if (directed && rmode == 0) begin
            checkOutput("first_word_cycle", first_cycle - start_cyc, 1);
            checkOutput("done_cycle", done_cycle - start_cyc, 25 + len);
            start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        @(negedge clk); #1;
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_tx_valid", tx_valid, 0);
        checkOutput("word_total", words_seen, 24 + len);
        checkOutput("din_taken", src_idx, len);
    endtask

    initial begin
        int n;
        doReset();

        // RX: two responses around a foreign tag
        rv_pulses = 0;
        @(posedge clk); #1 rx_valid = 1'b1; rx_cmd = 8'hEF; rx_lo = 64'h1234;
        @(posedge clk); #1 rx_cmd = 8'h05; rx_lo = 64'h9999;
        @(posedge clk); #1 rx_cmd = 8'hEF; rx_lo = 64'h5678;
        @(posedge clk); #1 rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rx_resp_data", resp_data, 64'h5678);
        checkOutput("rx_resp_count", resp_count, 2);
        checkOutput("rx_pulses", rv_pulses, 2);

        // directed loads: full load, data_len 0, toggling tx_rdy
        applyStimulus(3, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(3, 1, 1, 0);

        // randomized loads with background RX traffic
        rx_mode = 1;
        for (int k = 0; k < 6; k++) applyStimulus($urandom_range(0, 6), 0, k % 3, 1);

        // reset in the middle of the IV phase, then a full restart
        rdy_mode = 0; din_mode = 1;
        loadSetup(4, 0);
        n = 0;
        while (words_seen < 23 && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        checkOutput("iv_phase_reached", words_seen, 23);
        reset_n = 1'b0;
        #1;
        checkOutput("midreset_tx_valid", tx_valid, 0);
        checkOutput("midreset_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        applyStimulus(5, 0, 2, 1);

        // stalled TX channel
        rdy_mode = 3;
        loadSetup(2, 0);
`ifdef NOC16_LOADER_TIMEOUT_EN
        repeat (12) @(negedge clk);
        #1;
        checkOutput("timeout_err", err, 1);
        checkOutput("timeout_tx_valid", tx_valid, 0);
        checkOutput("timeout_busy", busy, 0);
        checkOutput("timeout_no_done", done_count, 0);
`else
        repeat (1000) @(negedge clk);
        #1;
        checkOutput("stall_busy", busy, 1);
        checkOutput("stall_tx_valid", tx_valid, 1);
        checkOutput("stall_err", err, 0);
        checkOutput("stall_words", words_seen, 0);
`endif
        rdy_mode = 0;
        doReset();
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
